// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between Execute and Write.
// Ports: in_* from Execute, dreq_*/dresp_* data bus, out_* to Write, flush.
package mem_pkg;
  typedef enum logic [3:0] {
    OP_ALU, OP_LB, OP_LBU, OP_LH, OP_LHU,
    OP_LW, OP_SB, OP_SH, OP_SW
  } op_t;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef struct packed {
    logic        valid;
    logic [4:0]  id;
    logic [31:0] value;
  } write_reg_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] hi;
    logic [31:0] lo;
  } write_hilo_t;

  typedef struct packed {
    logic        valid;
    logic        delayed;
    logic [4:0]  code;
    logic [31:0] bad_vaddr;
    logic [31:0] pc_src;
  } exception_t;

  typedef struct packed {
    logic [31:0] pc;
    op_t         op;
    write_reg_t  write_reg;
    write_hilo_t write_hilo;
    exception_t  exception;
  } write_context_t;
endpackage

module mem_stage
  import mem_pkg::*;
(
  input  logic           clk,
  input  logic           resetn,
  input  logic           in_valid,
  output logic           in_ready,
  input  write_context_t in_ctx,
  input  logic [31:0]    in_addr,
  input  logic [31:0]    in_sdata,
  input  logic           flush,
  output logic           dreq_valid,
  output logic           dreq_write,
  output logic [31:0]    dreq_addr,
  output logic [3:0]     dreq_strobe,
  output logic [31:0]    dreq_data,
  input  logic           dreq_addr_ok,
  input  logic           dresp_data_ok,
  input  logic [31:0]    dresp_data,
  output logic           out_valid,
  output write_context_t out_ctx
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t         state;
  write_context_t ctxQ;
  logic [1:0]     laneQ;

  logic           accept;
  logic           inLoad;
  logic           inStore;
  logic           misal;
  logic [3:0]     stbN;
  logic [31:0]    datN;
  write_context_t excCtx;

  logic           qLoad;
  logic [7:0]     lb;
  logic [15:0]    lh;
  logic [31:0]    loadVal;
  write_context_t doneCtx;

  assign in_ready = (state == IDLE) && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    inLoad  = 1'b0;
    inStore = 1'b0;
    misal   = 1'b0;
    stbN    = '0;
    datN    = '0;
    case (in_ctx.op)
      OP_LB, OP_LBU: inLoad = 1'b1;
      OP_LH, OP_LHU: begin
        inLoad = 1'b1;
        misal  = in_addr[0];
      end
      OP_LW: begin
        inLoad = 1'b1;
        misal  = |in_addr[1:0];
      end
      OP_SB: begin
        inStore = 1'b1;
        stbN    = 4'b0001 << in_addr[1:0];
        datN    = {4{in_sdata[7:0]}};
      end
      OP_SH: begin
        inStore = 1'b1;
        misal   = in_addr[0];
        stbN    = in_addr[1] ? 4'b1100 : 4'b0011;
        datN    = {2{in_sdata[15:0]}};
      end
      OP_SW: begin
        inStore = 1'b1;
        misal   = |in_addr[1:0];
        stbN    = 4'hF;
        datN    = in_sdata;
      end
      default: ;
    endcase
  end

  // Address-error context; delayed slot flag rides through untouched.
  always_comb begin
    excCtx = in_ctx;
    excCtx.exception.valid     = 1'b1;
    excCtx.exception.code      = inStore ? EXC_ADES : EXC_ADEL;
    excCtx.exception.bad_vaddr = in_addr;
    excCtx.exception.pc_src    = in_ctx.pc;
    excCtx.write_reg.valid     = 1'b0;
  end

  always_comb begin
    lb      = dresp_data[{laneQ, 3'b000} +: 8];
    lh      = laneQ[1] ? dresp_data[31:16] : dresp_data[15:0];
    qLoad   = 1'b0;
    loadVal = dresp_data;
    case (ctxQ.op)
      OP_LB: begin
        qLoad   = 1'b1;
        loadVal = {{24{lb[7]}}, lb};
      end
      OP_LBU: begin
        qLoad   = 1'b1;
        loadVal = {24'd0, lb};
      end
      OP_LH: begin
        qLoad   = 1'b1;
        loadVal = {{16{lh[15]}}, lh};
      end
      OP_LHU: begin
        qLoad   = 1'b1;
        loadVal = {16'd0, lh};
      end
      OP_LW: qLoad = 1'b1;
      default: ;
    endcase
    doneCtx = ctxQ;
    if (qLoad) doneCtx.write_reg.value = loadVal;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      ctxQ        <= '0;
      laneQ       <= '0;
      dreq_valid  <= 1'b0;
      dreq_write  <= 1'b0;
      dreq_addr   <= '0;
      dreq_strobe <= '0;
      dreq_data   <= '0;
      out_valid   <= 1'b0;
      out_ctx     <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if ((!inLoad && !inStore) || in_ctx.exception.valid) begin
              out_ctx   <= in_ctx;
              out_valid <= 1'b1;
            end else if (misal) begin
              out_ctx   <= excCtx;
              out_valid <= 1'b1;
            end else begin
              ctxQ        <= in_ctx;
              laneQ       <= in_addr[1:0];
              dreq_valid  <= 1'b1;
              dreq_write  <= inStore;
              dreq_addr   <= {in_addr[31:2], 2'b00};
              dreq_strobe <= stbN;
              dreq_data   <= datN;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          if (dreq_addr_ok || flush) dreq_valid <= 1'b0;
          if (flush) begin
            // An accepted load still owes a response unless it came now.
            if (dreq_addr_ok && qLoad && !dresp_data_ok) state <= DRAIN;
            else state <= IDLE;
          end else if (dreq_addr_ok) begin
            if (!qLoad || dresp_data_ok) begin
              out_ctx   <= doneCtx;
              out_valid <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dresp_data_ok) begin
            state <= IDLE;
            if (!flush) begin
              out_ctx   <= doneCtx;
              out_valid <= 1'b1;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (dresp_data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and random checks of mem_stage against a
// behavioural model of the load/store rules.
module tb_mem_stage;
  import mem_pkg::*;

  logic           clk;
  logic           resetn;
  logic           in_valid;
  logic           in_ready;
  write_context_t in_ctx;
  logic [31:0]    in_addr;
  logic [31:0]    in_sdata;
  logic           flush;
  logic           dreq_valid;
  logic           dreq_write;
  logic [31:0]    dreq_addr;
  logic [3:0]     dreq_strobe;
  logic [31:0]    dreq_data;
  logic           dreq_addr_ok;
  logic           dresp_data_ok;
  logic [31:0]    dresp_data;
  logic           out_valid;
  write_context_t out_ctx;

  int total = 0;
  int bad   = 0;

  mem_stage dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctx(in_ctx), .in_addr(in_addr), .in_sdata(in_sdata),
    .flush(flush),
    .dreq_valid(dreq_valid), .dreq_write(dreq_write),
    .dreq_addr(dreq_addr), .dreq_strobe(dreq_strobe),
    .dreq_data(dreq_data), .dreq_addr_ok(dreq_addr_ok),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_ctx(out_ctx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sizeOf(input op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic bit isLd(input op_t op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  endfunction

  function automatic logic [31:0] modelLoad(input op_t op,
      input logic [31:0] addr, input logic [31:0] w);
    logic [63:0] mask;
    logic [63:0] v;
    int off;
    off  = int'(addr % 4);
    mask = (64'd1 << (8 * sizeOf(op))) - 64'd1;
    v    = ({32'd0, w} >> (8 * off)) & mask;
    if ((op == OP_LB || op == OP_LH) && v > (mask >> 1)) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic write_context_t mkCtx(input op_t op, input bit exc);
    write_context_t c;
    c.pc                   = $urandom;
    c.op                   = op;
    c.write_reg.valid      = 1'($urandom);
    c.write_reg.id         = 5'($urandom);
    c.write_reg.value      = $urandom;
    c.write_hilo.valid     = 1'($urandom);
    c.write_hilo.hi        = $urandom;
    c.write_hilo.lo        = $urandom;
    c.exception.valid      = exc;
    c.exception.delayed    = 1'($urandom);
    c.exception.code       = 5'($urandom);
    c.exception.bad_vaddr  = $urandom;
    c.exception.pc_src     = $urandom;
    return c;
  endfunction

  // One instruction, from accept to one cycle past its result.
  // aWait: REQ cycles before addr_ok; dWait: cycles from addr_ok to data_ok.
  task automatic doTxn(input write_context_t ctx, input logic [31:0] addr,
      input logic [31:0] sdata, input logic [31:0] rdata,
      input int aWait, input int dWait);
    int sz;
    bit ld;
    bit st;
    bit bus;
    int mCyc;
    int kCyc;
    int outCyc;
    write_context_t expCtx;
    logic [3:0] expStb;
    logic [31:0] expData;
    sz  = sizeOf(ctx.op);
    ld  = isLd(ctx.op);
    st  = (sz != 0) && !ld;
    bus = 1'b0;
    expCtx = ctx;
    if (sz == 0 || ctx.exception.valid) begin
      bus = 1'b0;
    end else if (addr % sz != 0) begin
      expCtx.exception.valid     = 1'b1;
      expCtx.exception.code      = st ? 5'd5 : 5'd4;
      expCtx.exception.bad_vaddr = addr;
      expCtx.exception.pc_src    = ctx.pc;
      expCtx.write_reg.valid     = 1'b0;
    end else begin
      bus = 1'b1;
      if (ld) expCtx.write_reg.value = modelLoad(ctx.op, addr, rdata);
    end
    expStb  = st ? 4'(((1 << sz) - 1) << (addr % 4)) : 4'd0;
    expData = (sz == 1) ? sdata[7:0] * 32'h01010101 :
              (sz == 2) ? sdata[15:0] * 32'h00010001 : sdata;
    mCyc   = 1 + aWait;
    kCyc   = mCyc + dWait;
    outCyc = !bus ? 1 : (st ? mCyc + 1 : kCyc + 1);
    for (int c = 0; c <= outCyc + 1; c++) begin
      @(negedge clk);
      in_valid = (c == 0);
      if (c == 0) begin
        in_ctx   = ctx;
        in_addr  = addr;
        in_sdata = sdata;
      end else begin
        in_ctx   = mkCtx(OP_SW, 1'b0);
        in_addr  = $urandom;
        in_sdata = $urandom;
      end
      dreq_addr_ok  = bus && c == mCyc;
      dresp_data_ok = bus && ld && c == kCyc;
      dresp_data    = dresp_data_ok ? rdata : $urandom;
      #1;
      chk("in_ready", 256'(in_ready), 256'(c == 0 || c >= outCyc));
      chk("dreq_valid", 256'(dreq_valid),
          256'(bus && c >= 1 && c <= mCyc));
      if (bus && c >= 1 && c <= mCyc) begin
        chk("dreq_addr", 256'(dreq_addr), 256'(addr & 32'hFFFFFFFC));
        chk("dreq_write", 256'(dreq_write), 256'(st));
        chk("dreq_strobe", 256'(dreq_strobe), 256'(expStb));
        if (st) chk("dreq_data", 256'(dreq_data), 256'(expData));
      end
      chk("out_valid", 256'(out_valid), 256'(c == outCyc));
      if (c == outCyc) chk("out_ctx", 256'(out_ctx), 256'(expCtx));
    end
    in_valid      = 1'b0;
    dreq_addr_ok  = 1'b0;
    dresp_data_ok = 1'b0;
  endtask

  op_t ops [9] = '{OP_ALU, OP_LB, OP_LBU, OP_LH, OP_LHU,
                   OP_LW, OP_SB, OP_SH, OP_SW};

  initial begin
    write_context_t c0;
    write_context_t c1;
    write_context_t c2;
    resetn        = 1'b0;
    in_valid      = 1'b0;
    in_ctx        = '0;
    in_addr       = '0;
    in_sdata      = '0;
    flush         = 1'b0;
    dreq_addr_ok  = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_dreq_valid", 256'(dreq_valid), 256'(0));
    chk("rst_dreq_write", 256'(dreq_write), 256'(0));
    chk("rst_dreq_addr", 256'(dreq_addr), 256'(0));
    chk("rst_dreq_strobe", 256'(dreq_strobe), 256'(0));
    chk("rst_dreq_data", 256'(dreq_data), 256'(0));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_ctx", 256'(out_ctx), 256'(0));
    @(negedge clk);
    resetn = 1'b1;
    #1 chk("rst_in_ready", 256'(in_ready), 256'(1));
    flush = 1'b1;
    #1 chk("flush_in_ready", 256'(in_ready), 256'(0));
    flush = 1'b0;

    doTxn(mkCtx(OP_ALU, 1'b0), $urandom, $urandom, $urandom, 0, 0);

    doTxn(mkCtx(OP_LB, 1'b0), 32'h80000003, 0, 32'h80112233, 0, 0);
    chk("lb_value", 256'(out_ctx.write_reg.value), 256'(32'hFFFFFF80));
    doTxn(mkCtx(OP_LBU, 1'b0), 32'h80000003, 0, 32'h80112233, 0, 0);
    chk("lbu_value", 256'(out_ctx.write_reg.value), 256'(32'h00000080));

    doTxn(mkCtx(OP_SH, 1'b0), 32'h00001002, 32'h0000BEEF, 0, 3, 0);

    doTxn(mkCtx(OP_LW, 1'b0), 32'h00001001, 0, 0, 0, 0);
    chk("adel_code", 256'(out_ctx.exception.code), 256'(4));
    chk("adel_vaddr", 256'(out_ctx.exception.bad_vaddr), 256'(32'h1001));
    chk("adel_wr_valid", 256'(out_ctx.write_reg.valid), 256'(0));
    doTxn(mkCtx(OP_SW, 1'b0), 32'h00001002, 32'h12345678, 0, 0, 0);
    chk("ades_code", 256'(out_ctx.exception.code), 256'(5));

    // Load flushed while waiting for data: drains the response.
    @(negedge clk);
    in_valid = 1'b1;
    in_ctx   = mkCtx(OP_LW, 1'b0);
    in_addr  = 32'h00002000;
    #1 chk("fd_accept", 256'(in_ready), 256'(1));
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("fd_req1", 256'(dreq_valid), 256'(1));
    @(negedge clk);
    dreq_addr_ok = 1'b1;
    #1 chk("fd_req2", 256'(dreq_valid), 256'(1));
    @(negedge clk);
    dreq_addr_ok = 1'b0;
    flush = 1'b1;
    #1;
    chk("fd_wait_ready", 256'(in_ready), 256'(0));
    chk("fd_wait_dreq", 256'(dreq_valid), 256'(0));
    for (int c = 4; c <= 8; c++) begin
      @(negedge clk);
      flush         = 1'b0;
      dresp_data_ok = (c == 6);
      dresp_data    = $urandom;
      #1;
      chk("fd_in_ready", 256'(in_ready), 256'(c >= 7));
      chk("fd_out_valid", 256'(out_valid), 256'(0));
      chk("fd_dreq_valid", 256'(dreq_valid), 256'(0));
    end
    dresp_data_ok = 1'b0;

    // Store flushed in its addr_ok cycle: write issued, no result.
    @(negedge clk);
    in_valid = 1'b1;
    in_ctx   = mkCtx(OP_SW, 1'b0);
    in_addr  = 32'h00003000;
    @(negedge clk);
    in_valid     = 1'b0;
    dreq_addr_ok = 1'b1;
    flush        = 1'b1;
    #1 chk("sf_dreq", 256'(dreq_valid), 256'(1));
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      dreq_addr_ok = 1'b0;
      flush        = 1'b0;
      #1;
      chk("sf_out_valid", 256'(out_valid), 256'(0));
      chk("sf_dreq_off", 256'(dreq_valid), 256'(0));
      chk("sf_in_ready", 256'(in_ready), 256'(1));
    end

    // Flush while the request is still unaccepted.
    @(negedge clk);
    in_valid = 1'b1;
    in_ctx   = mkCtx(OP_LH, 1'b0);
    in_addr  = 32'h00004002;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b1;
    #1 chk("rf_dreq", 256'(dreq_valid), 256'(1));
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("rf_dreq_off", 256'(dreq_valid), 256'(0));
    chk("rf_in_ready", 256'(in_ready), 256'(1));
    chk("rf_out_valid", 256'(out_valid), 256'(0));

    // Back-to-back non-memory ops.
    c0 = mkCtx(OP_ALU, 1'b0);
    c1 = mkCtx(OP_ALU, 1'b0);
    c2 = mkCtx(OP_ALU, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_ctx   = c0;
    #1 chk("tp_rdy0", 256'(in_ready), 256'(1));
    @(negedge clk);
    in_ctx = c1;
    #1;
    chk("tp_rdy1", 256'(in_ready), 256'(1));
    chk("tp_ov1", 256'(out_valid), 256'(1));
    chk("tp_ctx1", 256'(out_ctx), 256'(c0));
    @(negedge clk);
    in_ctx = c2;
    #1;
    chk("tp_ov2", 256'(out_valid), 256'(1));
    chk("tp_ctx2", 256'(out_ctx), 256'(c1));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("tp_ov3", 256'(out_valid), 256'(1));
    chk("tp_ctx3", 256'(out_ctx), 256'(c2));
    @(negedge clk);
    #1 chk("tp_ov4", 256'(out_valid), 256'(0));

    for (int i = 0; i < 60; i++) begin
      op_t op;
      logic [31:0] a;
      int sz;
      op = ops[$urandom_range(0, 8)];
      a  = $urandom;
      sz = sizeOf(op);
      if (sz > 1 && $urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
      doTxn(mkCtx(op, $urandom_range(0, 7) == 0), a, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset while a load waits for data.
    @(negedge clk);
    in_valid = 1'b1;
    in_ctx   = mkCtx(OP_LW, 1'b0);
    in_addr  = 32'h00005000;
    @(negedge clk);
    in_valid     = 1'b0;
    dreq_addr_ok = 1'b1;
    @(negedge clk);
    dreq_addr_ok = 1'b0;
    #1;
    chk("rw_pre_addr", 256'(dreq_addr), 256'(32'h5000));
    resetn = 1'b0;
    #1;
    chk("rw_dreq_valid", 256'(dreq_valid), 256'(0));
    chk("rw_dreq_addr", 256'(dreq_addr), 256'(0));
    chk("rw_dreq_write", 256'(dreq_write), 256'(0));
    chk("rw_out_valid", 256'(out_valid), 256'(0));
    chk("rw_out_ctx", 256'(out_ctx), 256'(0));
    @(negedge clk);
    resetn        = 1'b1;
    dresp_data_ok = 1'b1;
    #1 chk("rw_in_ready", 256'(in_ready), 256'(1));
    @(negedge clk);
    dresp_data_ok = 1'b0;
    #1;
    chk("rw_no_out", 256'(out_valid), 256'(0));
    chk("rw_in_ready2", 256'(in_ready), 256'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
